// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding,
// the "101" pattern constant and a helper that sizes the bit index.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [2:0] PATTERN = 3'b101;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_101_counter.sv
// Saturating counter of overlapping "101" occurrences on a serial bit line.
// It can also sit beside a detector as an independent reference count.
module seq_101_counter
    import serial_pattern_tx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_bit,
    output logic [CNT_W-1:0] o_count
);

    logic [1:0]       r_hist;
    logic [CNT_W-1:0] r_count;
    logic             w_hit;
    logic             w_sat;

    assign w_hit = ({r_hist, i_bit} == PATTERN);
    assign w_sat = (r_count == {CNT_W{1'b1}});

    // The history keeps shifting every cycle, so overlapping matches are counted.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hist  <= '0;
            r_count <= '0;
        end else begin
            r_hist <= {r_hist[0], i_bit};
            if (w_hit && !w_sat) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serialises accepted parallel words MSB-first onto a single registered line,
// with optional idle gap between words and a running "101" self-check count.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic             o_out,
    output logic             o_frame,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_match_cnt
);

    localparam int              IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [3:0]       r_gap_cnt;
    logic [3:0]       w_gap_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_frame;
    logic             w_frame_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_accept;

    // r_idx counts bits still to follow the one on the line; zero means last bit.
    assign o_data_ready = (r_state == ST_IDLE) ||
                          ((GAP == 0) && (r_state == ST_SHIFT) && (r_idx == '0));
    assign w_accept     = i_data_valid && o_data_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_out     <= 1'b0;
            r_frame   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_out     <= w_out_nxt;
            r_frame   <= w_frame_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_gap_cnt_nxt = r_gap_cnt;
        w_out_nxt     = 1'b0;
        w_frame_nxt   = 1'b0;
        w_done_nxt    = 1'b0;

        // Accept can only occur in IDLE or on the last bit of a gapless stream.
        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_out_nxt   = i_data_in[WIDTH-1];
            w_shift_nxt = {i_data_in[WIDTH-2:0], 1'b0};
            w_idx_nxt   = LAST_IDX;
            w_frame_nxt = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (r_idx != '0) begin
                        w_out_nxt   = r_shift[WIDTH-1];
                        w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                        w_idx_nxt   = r_idx - 1'b1;
                        w_frame_nxt = 1'b1;
                        w_done_nxt  = (r_idx == IDX_W'(1));
                    end else if (GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign o_out   = r_out;
    assign o_frame = r_frame;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = r_done;

    seq_101_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_bit   (r_out),
        .o_count (o_match_cnt)
    );

endmodule
